// File: rtl/pipe_trace_recorder.sv
`default_nettype none
// ============================================================================
// Module      : pipe_trace_recorder
// Description : On-chip trace buffer. Each recorded cycle snapshots the
//               per-stage pipeline probes, tagged with a free-running cycle
//               stamp, into a circular RAM. A trigger splits the capture
//               into pre- and post-trigger parts. Once capture completes, the
//               buffer is read out oldest-first over a valid/ready port.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_trace_recorder #(
  parameter int CHANNELS = 4,
  parameter int WIDTH    = 16,
  parameter int DEPTH    = 16,
  parameter int CW       = 16,
  parameter int FILTER   = 0,
  localparam int AW      = $clog2(DEPTH),
  localparam int EW      = CW + CHANNELS + CHANNELS * WIDTH
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CHANNELS-1:0]       probe_v_i,
  input  logic [CHANNELS*WIDTH-1:0] probe_data_i,
  input  logic                      arm_i,
  input  logic                      trig_i,
  input  logic [AW:0]               post_i,
  input  logic                      rd_ready_i,
  output logic                      rd_valid_o,
  output logic [EW-1:0]             rd_data_o,
  output logic                      rd_last_o,
  output logic [1:0]                state_o,
  output logic [CW-1:0]             trig_stamp_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARMED = 2'd1,
    S_POST  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

  state_t        state, state_nxt;
  logic [CW-1:0] stamp;
  logic [AW-1:0] wr_ptr;
  logic [AW:0]   fill;
  logic [AW:0]   post_tgt;
  logic [AW:0]   remaining;
  logic [AW:0]   rd_cnt;
  logic [AW-1:0] rd_idx;
  logic [EW-1:0] mem [DEPTH];

  logic          rec;
  logic          wr_en;
  logic          do_trig;
  logic          rd_load;
  logic          rd_finish;
  logic [AW-1:0] rd_addr;
  logic [AW-1:0] rd_start;
  logic [AW:0]   post_clamped;

  // Buffer full means the oldest entry sits at the write pointer.
  assign rd_start     = fill[AW] ? wr_ptr : '0;
  assign rd_addr      = (rd_cnt == '0) ? rd_start : rd_idx;
  // post_i has one bit more than an index: MSB set means >= DEPTH.
  assign post_clamped = post_i[AW] ? DEPTH_W : post_i;
  assign state_o      = state;

  // Next-state decode and per-cycle control strobes.
  always_comb begin
    state_nxt = state;
    rec       = (FILTER == 0) || (|probe_v_i);
    wr_en     = 1'b0;
    do_trig   = 1'b0;
    rd_load   = 1'b0;
    rd_finish = 1'b0;
    if (arm_i) begin
      state_nxt = S_ARMED;
    end else begin
      case (state)
        S_ARMED: begin
          wr_en = rec;
          if (trig_i) begin
            do_trig   = 1'b1;
            state_nxt = (post_tgt == '0) ? S_DONE : S_POST;
          end
        end
        S_POST: begin
          wr_en = rec;
          if (rec && remaining == (AW+1)'(1)) begin
            state_nxt = S_DONE;
          end
        end
        S_DONE: begin
          if (fill == '0) begin
            state_nxt = S_IDLE;
          end else if (rd_valid_o && rd_ready_i && rd_last_o) begin
            state_nxt = S_IDLE;
            rd_finish = 1'b1;
          end else if (!rd_valid_o || rd_ready_i) begin
            rd_load = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // State register, capture bookkeeping and readout registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= S_IDLE;
      stamp        <= '0;
      wr_ptr       <= '0;
      fill         <= '0;
      post_tgt     <= '0;
      remaining    <= '0;
      rd_cnt       <= '0;
      rd_idx       <= '0;
      rd_valid_o   <= 1'b0;
      rd_last_o    <= 1'b0;
      rd_data_o    <= '0;
      trig_stamp_o <= '0;
    end else begin
      state <= state_nxt;
      stamp <= stamp + 1'b1;
      if (arm_i) begin
        wr_ptr     <= '0;
        fill       <= '0;
        post_tgt   <= post_clamped;
        remaining  <= '0;
        rd_cnt     <= '0;
        rd_valid_o <= 1'b0;
        rd_last_o  <= 1'b0;
      end else begin
        if (wr_en) begin
          wr_ptr <= wr_ptr + 1'b1;
          if (!fill[AW]) begin
            fill <= fill + 1'b1;
          end
        end
        if (do_trig) begin
          trig_stamp_o <= stamp;
          remaining    <= post_tgt;
        end
        if (state == S_POST && wr_en) begin
          remaining <= remaining - 1'b1;
        end
        if (rd_load) begin
          rd_data_o  <= mem[rd_addr];
          rd_valid_o <= 1'b1;
          rd_last_o  <= ((rd_cnt + 1'b1) == fill);
          rd_idx     <= rd_addr + 1'b1;
          rd_cnt     <= rd_cnt + 1'b1;
        end
        if (rd_finish) begin
          rd_valid_o <= 1'b0;
          rd_last_o  <= 1'b0;
        end
      end
    end
  end

  // Trace RAM write port; contents are never reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= {stamp, probe_v_i, probe_data_i};
    end
  end

endmodule
`default_nettype wire
